ulx3s_pll_reset_sequencer: RTL
==============================

# ulx3s_pll_reset_sequencer

Reset and lock supervisor for the ECP5 EHXPLLL clock generator on the ULX3S RISC-ICE-V build. Runs on the 25 MHz board clock, drives the PLL `RST` pin, qualifies `LOCK`, and releases per-domain resets in a fixed order: memory, CPU unit, co-processor, CPU. It re-acquires lock automatically on lock loss or lock timeout, so the CPU never runs on an unstable clock.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset attempt (≥2).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAITLOCK before a retry.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required.
- `STAGE_GAP_CYCLES`, 8: spacing between successive domain releases (≥1).
- `NUM_DOMAINS`, 4: number of domain resets; index 0 is released first.

Ports:
- `clkin`, in, 1: 25 MHz board clock; the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `locked`, in, 1: PLL `LOCK`, asynchronous to `clkin`.
- `soft_rst_req`, in, 1: one-cycle pulse that requests a full re-sequence.
- `pll_rst`, out, 1: to EHXPLLL `RST`, active-high. The PLL instance is built with `PLLRST_ENA("ENABLED")`.
- `domain_rst_n`, out, `NUM_DOMAINS`: per-domain active-low resets, registered in `clkin`. Each consuming domain resynchronizes its own deassertion.
- `ready`, out, 1: all domains released and lock is good.
- `retry_count`, out, 8: number of lock-timeout retries, saturating at 255.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. No other logic samples raw `locked`.
- One down/up counter `cnt`, sized to `$clog2` of the largest count parameter plus 1. One stage index `idx`.
- States and transitions:
  - PLLRST: `pll_rst`=1, all `domain_rst_n`=0. After `PLL_RST_CYCLES` cycles, go to WAITLOCK.
  - WAITLOCK: `pll_rst`=0. If `locked_s`=1, go to STABLE. If `LOCK_TIMEOUT_CYCLES` elapse first, go to PLLRST and increment `retry_count`, saturating at 255.
  - STABLE: counts consecutive cycles with `locked_s`=1. If `locked_s`=0, go to WAITLOCK with the timeout restarted. After `LOCK_STABLE_CYCLES`, go to RELEASE with `idx`=0.
  - RELEASE: on entry, set `domain_rst_n[0]`=1. Every `STAGE_GAP_CYCLES` after that, set `domain_rst_n[idx+1]`=1. `STAGE_GAP_CYCLES` after the last domain is released, go to RUN.
  - RUN: `ready`=1.
- Lock loss (`locked_s`=0) in RELEASE or RUN:
  - The next register update drives all `domain_rst_n`=0 and `ready`=0.
  - State goes to WAITLOCK. The PLL is not reset.
  - `retry_count` is unchanged.
- `soft_rst_req` in any state other than PLLRST forces PLLRST with all resets asserted. `retry_count` is unchanged. In PLLRST the request is ignored.
- Priority when events coincide: lock loss, then `soft_rst_req`, then timeout/count expiry.
- `domain_rst_n` bits never deassert out of order. Once a bit is released it stays released until the next lock loss, soft request, or `rst_n`.

## Timing
- Values while `rst_n`=0: state PLLRST, `pll_rst`=1, `domain_rst_n`=0, `ready`=0, `retry_count`=0, `cnt`=0, synchronizer flops 0.
- After `rst_n` deasserts, `pll_rst` stays 1 for exactly `PLL_RST_CYCLES` rising edges.
- `locked` rising at edge k, with state WAITLOCK:
  - `domain_rst_n[0]` rises at edge k+3+`LOCK_STABLE_CYCLES`.
  - `domain_rst_n[i]` rises at that edge + i·`STAGE_GAP_CYCLES`.
  - `ready` rises `STAGE_GAP_CYCLES` after the last domain release.
- `locked` falling at edge k in RUN: `domain_rst_n` = 0 and `ready` = 0 at edge k+3. This is 2 synchronizer cycles plus 1 output register.
- `rst_n` asserted mid-sequence asynchronously restores every reset value immediately.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `risc_ice_v_clk_pkg`:
  - state enum `seq_state_t` (PLLRST, WAITLOCK, STABLE, RELEASE, RUN);
  - domain index constants `DOM_MEMORY`=0, `DOM_CPUUNIT`=1, `DOM_COPRO`=2, `DOM_CPU`=3.
- One sub-module: `sync2`, a 2-flop synchronizer with async active-low reset, used for `locked`.
- The top level wires `pll_rst` to the PLL `RST` pin and `domain_rst_n[DOM_*]` to each clock domain's reset synchronizer.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=2, NUM_DOMAINS=4.
1. Clean bring-up: release `rst_n`, raise `locked` at edge 10 → `pll_rst` high on edges 0–3; `domain_rst_n` goes 0001, 0011, 0111, 1111 at edges 21, 23, 25, 27; `ready`=1 at edge 29.
2. Lock never arrives: hold `locked`=0 → a `pll_rst` pulse of 4 cycles every 36 cycles; `retry_count` reads 1, 2, 3…; no domain is released.
3. Lock glitch during STABLE: drop `locked` for 1 cycle after 5 stable cycles → the stable count restarts; first release happens 8 synchronized cycles after relock.
4. Lock loss in RUN: drop `locked` at edge k → `domain_rst_n`=0000 and `ready`=0 at edge k+3; `pll_rst` stays 0; after relock the staged release repeats.
5. Soft request in RUN: pulse `soft_rst_req` → next edge `pll_rst`=1 and all resets asserted; full sequence repeats; `retry_count` unchanged.
6. Async reset mid-RELEASE: assert `rst_n` low with `domain_rst_n`=0011 → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ulx3s_pll_reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// risc_ice_v_clk_pkg
// Shared definitions for the RISC-ICE-V clock/reset supervisor:
//   - sequencer state encoding (legacy-compatible constants plus enum view)
//   - clock-domain indices into domain_rst_n, in release order
//   - saturating 8-bit increment used by the retry counter
// ---------------------------------------------------------------------------
package risc_ice_v_clk_pkg;

  localparam logic [2:0] S_PLLRST   = 3'd0;
  localparam logic [2:0] S_WAITLOCK = 3'd1;
  localparam logic [2:0] S_STABLE   = 3'd2;
  localparam logic [2:0] S_RELEASE  = 3'd3;
  localparam logic [2:0] S_RUN      = 3'd4;

  typedef enum logic [2:0] {
    PLLRST   = S_PLLRST,
    WAITLOCK = S_WAITLOCK,
    STABLE   = S_STABLE,
    RELEASE  = S_RELEASE,
    RUN      = S_RUN
  } seq_state_t;

  // Domain indices; index 0 is released first.
  localparam int DOM_MEMORY  = 32'd0;
  localparam int DOM_CPUUNIT = 32'd1;
  localparam int DOM_COPRO   = 32'd2;
  localparam int DOM_CPU     = 32'd3;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      satInc8 = value;
    end else begin
      satInc8 = value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/ulx3s_pll_reset_sequencer_sync2.sv
// ---------------------------------------------------------------------------
// sync2 - two-flop synchronizer with asynchronous active-low reset.
// Ports:
//   clk   in  : destination clock
//   rst_n in  : async active-low reset, clears both flops to 0
//   d     in  : asynchronous input
//   q     out : synchronized output (2 cycles of latency)
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage metastability filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ulx3s_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// ulx3s_pll_reset_sequencer - reset and lock supervisor for the ECP5 EHXPLLL.
// Holds the PLL in reset, waits for a qualified lock, then releases the
// per-domain resets one by one (memory, CPU unit, co-processor, CPU).
// Lock loss drops every domain reset and waits for relock without resetting
// the PLL; a lock timeout or a soft request re-runs the full PLL reset.
// Ports:
//   clkin        in  : 25 MHz board clock, the only clock
//   rst_n        in  : async active-low reset
//   locked       in  : PLL LOCK, asynchronous to clkin
//   soft_rst_req in  : one-cycle pulse requesting a full re-sequence
//   pll_rst      out : EHXPLLL RST, active high
//   domain_rst_n out : per-domain active-low resets, index 0 released first
//   ready        out : all domains released and lock good
//   retry_count  out : lock-timeout retries, saturating at 255
// ---------------------------------------------------------------------------
module ulx3s_pll_reset_sequencer
  import risc_ice_v_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 8,
  parameter int NUM_DOMAINS         = 4
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   locked,
  input  logic                   soft_rst_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic [7:0]             retry_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CNT) + 32'd1;
  localparam int IDX_W   = (NUM_DOMAINS > 32'd1) ? $clog2(NUM_DOMAINS) : 32'd1;

  // Counter compares against "cycles - 1" because the counter is cleared on
  // the same edge that enters a state.
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 32'sd1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 32'sd1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1'b1);

  seq_state_t             state_r,      stateNext_s;
  logic [CNT_W-1:0]       cnt_r,        cntNext_s;
  logic [IDX_W-1:0]       idx_r,        idxNext_s;
  logic [NUM_DOMAINS-1:0] domRstN_r,    domNext_s;
  logic [7:0]             retryCount_r, retryNext_s;
  logic                   pllRst_r;
  logic                   ready_r;
  logic                   lockedSync_s;

  sync2 uLockSync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lockedSync_s)
  );

  // Next-state logic; priority is lock loss, then soft request, then expiry.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r + CNT_ONE;
    idxNext_s   = idx_r;
    domNext_s   = domRstN_r;
    retryNext_s = retryCount_r;
    case (state_r)
      PLLRST: begin
        domNext_s = '0;
        if (cnt_r == PLL_LAST) begin
          stateNext_s = WAITLOCK;
          cntNext_s   = '0;
        end else begin
          stateNext_s = PLLRST;
        end
      end
      WAITLOCK: begin
        domNext_s = '0;
        if (soft_rst_req) begin
          stateNext_s = PLLRST;
          cntNext_s   = '0;
        end else if (lockedSync_s) begin
          stateNext_s = STABLE;
          cntNext_s   = '0;
        end else if (cnt_r == TIMEOUT_LAST) begin
          stateNext_s = PLLRST;
          cntNext_s   = '0;
          retryNext_s = satInc8(retryCount_r);
        end else begin
          stateNext_s = WAITLOCK;
        end
      end
      STABLE: begin
        domNext_s = '0;
        if (!lockedSync_s) begin
          stateNext_s = WAITLOCK;
          cntNext_s   = '0;
        end else if (soft_rst_req) begin
          stateNext_s = PLLRST;
          cntNext_s   = '0;
        end else if (cnt_r == STABLE_LAST) begin
          // First domain is released on the same edge RELEASE is entered.
          stateNext_s           = RELEASE;
          cntNext_s             = '0;
          idxNext_s             = '0;
          domNext_s[DOM_MEMORY] = 1'b1;
        end else begin
          stateNext_s = STABLE;
        end
      end
      RELEASE: begin
        if (!lockedSync_s) begin
          stateNext_s = WAITLOCK;
          cntNext_s   = '0;
          domNext_s   = '0;
        end else if (soft_rst_req) begin
          stateNext_s = PLLRST;
          cntNext_s   = '0;
          domNext_s   = '0;
        end else if (cnt_r == GAP_LAST) begin
          cntNext_s = '0;
          if (idx_r == IDX_LAST) begin
            stateNext_s = RUN;
          end else begin
            idxNext_s = idx_r + IDX_ONE;
            domNext_s = domRstN_r | (DOM_ONE << (idx_r + IDX_ONE));
          end
        end else begin
          stateNext_s = RELEASE;
        end
      end
      RUN: begin
        cntNext_s = cnt_r;
        if (!lockedSync_s) begin
          stateNext_s = WAITLOCK;
          cntNext_s   = '0;
          domNext_s   = '0;
        end else if (soft_rst_req) begin
          stateNext_s = PLLRST;
          cntNext_s   = '0;
          domNext_s   = '0;
        end else begin
          stateNext_s = RUN;
        end
      end
      default: begin
        stateNext_s = PLLRST;
        cntNext_s   = '0;
        idxNext_s   = '0;
        domNext_s   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= PLLRST;
      cnt_r        <= '0;
      idx_r        <= '0;
      domRstN_r    <= '0;
      retryCount_r <= 8'd0;
      pllRst_r     <= 1'b1;
      ready_r      <= 1'b0;
    end else begin
      state_r      <= stateNext_s;
      cnt_r        <= cntNext_s;
      idx_r        <= idxNext_s;
      domRstN_r    <= domNext_s;
      retryCount_r <= retryNext_s;
      pllRst_r     <= (stateNext_s == PLLRST);
      ready_r      <= (stateNext_s == RUN);
    end
  end

  assign pll_rst      = pllRst_r;
  assign domain_rst_n = domRstN_r;
  assign ready        = ready_r;
  assign retry_count  = retryCount_r;

endmodule
